uart_tx_scheduler: RTL and testbench

//  Shares the single memory-mapped UART transmitter between NUM_REQ byte producers (CPU port, debug monitor, ...).

---
 rtl/uart_sched_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 35 +++
 rtl/uart_tx_scheduler.sv | 155 +++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_sched_pkg.sv
// uart_sched_pkg -- shared states and UART register map for uart_tx_scheduler.
// Rev 1.0
`default_nettype none

package uart_sched_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WR_DATA    = 3'd1,
    WR_CTRL    = 3'd2,
    WAIT_START = 3'd3,
    WAIT_DONE  = 3'd4
  } state_t;

  localparam logic [1:0] REG_DATA        = 2'b00;
  localparam logic [1:0] REG_CTRL        = 2'b10;
  localparam logic [1:0] REG_STATUS      = 2'b11;
  localparam logic [7:0] CTRL_GO         = 8'h01;
  localparam int         STATUS_BUSY_BIT = 0;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// rr_arbiter -- combinational round-robin pick; search starts at ptr and wraps.
// Rev 1.0
`default_nettype none

module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      idx
);

  logic found;
  int   cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = IW'(cand);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler -- round-robin sharing of one memory-mapped UART transmitter.
// Rev 1.0. Optional abort-on-timeout: define UART_SCHED_TIMEOUT_EN.
`default_nettype none

module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int START_TIMEOUT = 1024,
  parameter int DONE_TIMEOUT  = 8192
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [8*NUM_REQ-1:0]         req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         busy,
  output logic                         uart_we,
  output logic                         uart_re,
  output logic [1:0]                   uart_sel,
  output logic [7:0]                   uart_wdata,
  input  logic [7:0]                   uart_rdata,
  output logic                         timeout_err
);

  localparam int IW = $clog2(NUM_REQ);

  state_t          state, state_nxt;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   ptr_after;
  logic [7:0]      byte_q;
  logic [NUM_REQ-1:0] arb_grant;
  logic [IW-1:0]   arb_idx;
  logic            accept, finish, abort;
  logic            tmo_hit;
  logic            uart_busy;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  assign uart_busy = uart_rdata[STATUS_BUSY_BIT];
  assign busy      = (state != IDLE);
  // Served (or aborted) requester drops to lowest priority next round.
  assign ptr_after = (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

`ifdef UART_SCHED_TIMEOUT_EN
  logic [13:0] tmo_cnt;
  logic        err_q;

  assign tmo_hit = ((state == WAIT_START) && (tmo_cnt == 14'(START_TIMEOUT - 1))) ||
                   ((state == WAIT_DONE)  && (tmo_cnt == 14'(DONE_TIMEOUT - 1)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= abort;
      if (state_nxt != state)
        tmo_cnt <= '0;
      else if (state == WAIT_START || state == WAIT_DONE)
        tmo_cnt <= tmo_cnt + 14'd1;
    end
  end

  assign timeout_err = err_q;
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      byte_q   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        byte_q   <= req_data[8*int'(arb_idx) +: 8];
        grant_id <= arb_idx;
      end
      if (finish || abort)
        rr_ptr <= ptr_after;
    end
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = '0;
    uart_we    = 1'b0;
    uart_re    = 1'b0;
    uart_sel   = REG_DATA;
    uart_wdata = '0;
    accept     = 1'b0;
    finish     = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        req_ready = arb_grant;
        if (|req_valid) begin
          accept    = 1'b1;
          state_nxt = WR_DATA;
        end
      end
      WR_DATA: begin
        uart_we    = 1'b1;
        uart_sel   = REG_DATA;
        uart_wdata = byte_q;
        state_nxt  = WR_CTRL;
      end
      WR_CTRL: begin
        uart_we    = 1'b1;
        uart_sel   = REG_CTRL;
        uart_wdata = CTRL_GO;
        state_nxt  = WAIT_START;
      end
      WAIT_START: begin
        uart_re  = 1'b1;
        uart_sel = REG_STATUS;
        // A busy observation wins over a timeout expiring in the same cycle.
        if (uart_busy) begin
          state_nxt = WAIT_DONE;
        end else if (tmo_hit) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end
      end
      WAIT_DONE: begin
        uart_re  = 1'b1;
        uart_sel = REG_STATUS;
        if (!uart_busy) begin
          finish    = 1'b1;
          state_nxt = IDLE;
        end else if (tmo_hit) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler -- directed checks of uart_tx_scheduler against a small UART model.
// Rev 1.0
`default_nettype none

module tb_uart_tx_scheduler;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic [1:0]     grant_id;
  logic           busy, uart_we, uart_re, timeout_err;
  logic [1:0]     uart_sel;
  logic [7:0]     uart_wdata, uart_rdata;

  uart_tx_scheduler #(.NUM_REQ(N)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .grant_id(grant_id), .busy(busy),
    .uart_we(uart_we), .uart_re(uart_re), .uart_sel(uart_sel),
    .uart_wdata(uart_wdata), .uart_rdata(uart_rdata), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // UART model: busy rises start_delay clks after a go write, stays busy_len clks.
  int       start_delay = 3;
  int       busy_len    = 5;
  bit       never_busy  = 0;
  logic     m_busy, m_pend;
  int       m_dly, m_left;
  int       we_count;
  logic [7:0] rx_bytes[$];

  assign uart_rdata = {7'b0, m_busy};

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy <= 1'b0; m_pend <= 1'b0; m_dly <= 0; m_left <= 0;
    end else begin
      if (uart_we) we_count <= we_count + 1;
      if (uart_we && uart_sel == 2'b00) rx_bytes.push_back(uart_wdata);
      if (uart_we && uart_sel == 2'b10 && uart_wdata == 8'h01 && !never_busy) begin
        m_pend <= 1'b1; m_dly <= start_delay;
      end else if (m_pend) begin
        if (m_dly <= 1) begin
          m_pend <= 1'b0; m_busy <= 1'b1; m_left <= busy_len;
        end else m_dly <= m_dly - 1;
      end
      if (m_busy) begin
        if (m_left <= 1) m_busy <= 1'b0;
        else m_left <= m_left - 1;
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 2000 && busy; i++) @(negedge clk);
    check(tag, busy, 1'b0);
  endtask

  // Present one request at a negedge; returns at the WR_DATA negedge.
  task automatic send(input int idx, input logic [7:0] b);
    req_data[8*idx +: 8] = b;
    req_valid = N'(1) << idx;
    @(negedge clk);
    req_valid = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  int base, wc, k;
  bit saw_err;
  logic [7:0] exp_rr[5];

  initial begin
    we_count  = 0;
    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check("rst_busy", busy, 0);
    check("rst_we_re", {uart_we, uart_re}, 2'b00);
    check("rst_sel_wdata", {uart_sel, uart_wdata}, 10'h000);
    check("rst_grant_err", {grant_id, timeout_err}, 3'b000);

    // Single byte from requester 1
    base = rx_bytes.size();
    req_data[15:8] = 8'h68;
    req_valid = 4'b0010;
    #1;
    check("single_ready", req_ready, 4'b0010);
    @(negedge clk);
    req_valid = '0;
    check("single_wr_data", {uart_we, uart_sel, uart_wdata}, {1'b1, 2'b00, 8'h68});
    check("single_grant", grant_id, 2'd1);
    check("single_ready_off", req_ready, 4'b0000);
    @(negedge clk);
    check("single_wr_ctrl", {uart_we, uart_sel, uart_wdata}, {1'b1, 2'b10, 8'h01});
    @(negedge clk);
    check("single_poll", {uart_we, uart_re, uart_sel}, {1'b0, 1'b1, 2'b11});
    wait_idle("single_done");
    check("single_count", rx_bytes.size() - base, 1);
    check("single_byte", rx_bytes[base], 8'h68);
    check("idle_sel", {uart_we, uart_re, uart_sel}, 4'b0000);

    // Reset while in WAIT_DONE; the byte must not be retried
    busy_len = 50;
    send(2, 8'h33);
    for (int i = 0; i < 100 && !m_busy; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("pre_rst_wait_done", {busy, uart_re, m_busy}, 3'b111);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_state", {busy, uart_we, uart_re, timeout_err}, 4'b0000);
    reset = 1'b0;
    wc = we_count;
    repeat (20) @(negedge clk);
    check("midrst_no_retry", we_count - wc, 0);
    check("midrst_idle", busy, 0);
    busy_len = 5;

    // Round robin from pointer 0 with all requesters held
    base = rx_bytes.size();
    req_data  = {8'h44, 8'h43, 8'h42, 8'h41};
    req_valid = 4'b1111;
    for (int i = 0; i < 500 && rx_bytes.size() < base + 5; i++) @(negedge clk);
    req_valid = '0;
    wait_idle("rr_done");
    check("rr_count", rx_bytes.size() - base, 5);
    exp_rr = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h41};
    for (int i = 0; i < 5; i++)
      if (base + i < rx_bytes.size()) check($sformatf("rr_byte%0d", i), rx_bytes[base + i], exp_rr[i]);

    // Pointer wrap: serve 3, then 0 must win over 3
    send(3, 8'hD3);
    wait_idle("wrap_serve3");
    req_data[7:0] = 8'hA0;
    req_valid = 4'b1001;
    #1;
    check("wrap_ready0", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = '0;
    check("wrap_grant0", {grant_id, uart_wdata}, {2'd0, 8'hA0});
    wait_idle("wrap_serve0");
    req_valid = 4'b1001;
    #1;
    check("after0_ready3", req_ready, 4'b1000);
    @(negedge clk);
    req_valid = '0;
    check("after0_grant3", {grant_id, uart_wdata}, {2'd3, 8'hD3});
    wait_idle("after0_done");

    // UART never reports busy
    never_busy = 1;
    do_reset();
    send(0, 8'h77);
    repeat (2) @(negedge clk);
    check("stuck_poll", uart_re, 1);
    saw_err = 0;
`ifdef UART_SCHED_TIMEOUT_EN
    k = 0;
    while (k < 1200 && !timeout_err) begin
      @(negedge clk);
      k++;
    end
    check("tmo_cycles", k, 1024);
    check("tmo_idle", {timeout_err, busy, uart_re}, 3'b100);
    @(negedge clk);
    check("tmo_pulse_1clk", timeout_err, 0);
    never_busy = 0;
    req_valid = 4'b0011;
    #1;
    check("tmo_ptr_advance", req_ready, 4'b0010);
    @(negedge clk);
    req_valid = '0;
    wait_idle("tmo_after");
`else
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      saw_err |= timeout_err;
    end
    check("stuck_busy", {busy, uart_re}, 2'b11);
    check("stuck_no_err", saw_err, 0);
`endif
    never_busy = 0;
    do_reset();

    // Slow baud: busy appears 200 clks after go
    start_delay = 200;
    busy_len    = 20;
    base = rx_bytes.size();
    wc   = we_count;
    send(2, 8'h5A);
    wait_idle("slow_done");
    check("slow_writes", we_count - wc, 2);
    check("slow_count", rx_bytes.size() - base, 1);
    if (rx_bytes.size() > base) check("slow_byte", rx_bytes[base], 8'h5A);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
